// File: rtl/alu_fu_pkg.sv
// Shared types for the ALU functional unit: operand/tag widths, op codes,
// issue packet from the reservation station and the CDB result packet.
package alu_fu_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [ROB_W-1:0]  rob_t;

    // Codes 12..15 are unassigned and produce a zero result.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    typedef struct packed {
        xlen_t   pc;
        rob_t    rob_tag;
        preg_t   rs1_tag;
        preg_t   rs2_tag;
        preg_t   rd_tag;
        logic    rd_used;
        alu_op_e alu_op;
        xlen_t   imm;
        logic    src2_is_imm;
        logic    src1_is_pc;
    } issue_pkt_t;

    // Stage-A copy of the issue packet; source tags are consumed at issue time.
    typedef struct packed {
        xlen_t   pc;
        rob_t    rob_tag;
        preg_t   rd_tag;
        logic    rd_used;
        alu_op_e alu_op;
        xlen_t   imm;
        logic    src2_is_imm;
        logic    src1_is_pc;
    } a_pkt_t;

    typedef struct packed {
        rob_t  rob_tag;
        preg_t rd_tag;
        logic  rd_used;
        xlen_t value;
    } cdb_pkt_t;

    function automatic a_pkt_t to_a_pkt(input issue_pkt_t p);
        a_pkt_t a;
        a.pc          = p.pc;
        a.rob_tag     = p.rob_tag;
        a.rd_tag      = p.rd_tag;
        a.rd_used     = p.rd_used;
        a.alu_op      = p.alu_op;
        a.imm         = p.imm;
        a.src2_is_imm = p.src2_is_imm;
        a.src1_is_pc  = p.src1_is_pc;
        return a;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Integer ALU datapath: op1/op2/alu_op -> result.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns all handshaking.
module alu_core
    import alu_fu_pkg::*;
(
    input  xlen_t   op1,
    input  xlen_t   op2,
    input  alu_op_e alu_op,
    output xlen_t   result
);

    logic [4:0] shamt;

    always_comb begin
        shamt  = op2[4:0];
        result = '0;
        case (alu_op)
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_AND:   result = op1 & op2;
            ALU_OR:    result = op1 | op2;
            ALU_XOR:   result = op1 ^ op2;
            ALU_SLL:   result = op1 << shamt;
            ALU_SRL:   result = op1 >> shamt;
            ALU_SRA:   result = xlen_t'($signed(op1) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            // The pipeline steers imm into op2 (and pc into op1 for AUIPC).
            ALU_LUI:   result = op2;
            ALU_AUIPC: result = op1 + op2;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_fu.sv
// ALU functional unit: issue packet -> PRF operand read (A) -> result register (O) -> CDB.
// Latency: 2 cycles fire-to-cdb_valid_o when unstalled; 1 op/cycle throughput.
// Backpressure: cdb_ready_i low stalls O then A; issue_ready_o drops once both are held.
module alu_fu
    import alu_fu_pkg::*;
#(
    parameter int XLEN   = alu_fu_pkg::XLEN,
    parameter int PREG_W = alu_fu_pkg::PREG_W,
    parameter int ROB_W  = alu_fu_pkg::ROB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  issue_pkt_t        issue_pkt_i,
    output logic [PREG_W-1:0] prf_rs1_addr_o,
    output logic [PREG_W-1:0] prf_rs2_addr_o,
    input  logic [XLEN-1:0]   prf_rs1_data_i,
    input  logic [XLEN-1:0]   prf_rs2_data_i,
    output logic              cdb_valid_o,
    input  logic              cdb_ready_i,
    output cdb_pkt_t          cdb_pkt_o
);

    generate
        if (XLEN != $bits(xlen_t) || PREG_W != $bits(preg_t) || ROB_W != $bits(rob_t)) begin : g_bad_param
            $error("alu_fu parameters disagree with alu_fu_pkg widths");
        end
    endgenerate

    logic     a_valid;
    logic     a_fresh;
    a_pkt_t   a_pkt;
    xlen_t    rs1_hold;
    xlen_t    rs2_hold;
    logic     o_valid;
    cdb_pkt_t o_pkt;

    logic     o_adv;
    logic     a_adv;
    logic     fire;
    xlen_t    rs1_val;
    xlen_t    rs2_val;
    xlen_t    op1;
    xlen_t    op2;
    xlen_t    alu_res;
    cdb_pkt_t a_result;

    assign prf_rs1_addr_o = issue_pkt_i.rs1_tag;
    assign prf_rs2_addr_o = issue_pkt_i.rs2_tag;

    assign o_adv         = !o_valid || cdb_ready_i;
    assign a_adv         = a_valid && o_adv;
    assign issue_ready_o = !flush_i && (!a_valid || o_adv);
    assign fire          = issue_valid_i && issue_ready_o;

    // PRF data is only valid the cycle after capture; afterwards use the held copy.
    always_comb begin
        rs1_val = a_fresh ? prf_rs1_data_i : rs1_hold;
        rs2_val = a_fresh ? prf_rs2_data_i : rs2_hold;
        op1 = (a_pkt.src1_is_pc || a_pkt.alu_op == ALU_AUIPC) ? a_pkt.pc : rs1_val;
        op2 = (a_pkt.src2_is_imm || a_pkt.alu_op == ALU_LUI || a_pkt.alu_op == ALU_AUIPC)
              ? a_pkt.imm : rs2_val;
    end

    alu_core u_alu_core (
        .op1    (op1),
        .op2    (op2),
        .alu_op (a_pkt.alu_op),
        .result (alu_res)
    );

    always_comb begin
        a_result         = '0;
        a_result.rob_tag = a_pkt.rob_tag;
        a_result.rd_tag  = a_pkt.rd_tag;
        a_result.rd_used = a_pkt.rd_used;
        a_result.value   = a_pkt.rd_used ? alu_res : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid  <= 1'b0;
            a_fresh  <= 1'b0;
            a_pkt    <= '0;
            rs1_hold <= '0;
            rs2_hold <= '0;
            o_valid  <= 1'b0;
            o_pkt    <= '0;
        end else if (flush_i) begin
            a_valid <= 1'b0;
            a_fresh <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            if (o_adv) begin
                o_valid <= a_valid;
                if (a_valid) begin
                    o_pkt <= a_result;
                end
            end

            if (fire) begin
                a_valid <= 1'b1;
                a_fresh <= 1'b1;
                a_pkt   <= to_a_pkt(issue_pkt_i);
            end else if (a_adv) begin
                a_valid <= 1'b0;
                a_fresh <= 1'b0;
            end else if (a_valid && a_fresh) begin
                rs1_hold <= prf_rs1_data_i;
                rs2_hold <= prf_rs2_data_i;
                a_fresh  <= 1'b0;
            end
        end
    end

    assign cdb_valid_o = o_valid;
    assign cdb_pkt_o   = o_pkt;

endmodule

// File: doc/alu_fu.md
Name: alu_fu

Overview:
- Consumer end of the ALU issue interface. Accepts issue_pkt_t from the ALU reservation station with a valid/ready handshake.
- Reads both source operands from the physical register file (PRF), executes one integer ALU op, and presents a cdb_pkt_t result to the CDB/writeback arbiter with a valid/ready handshake.
- Two-stage pipeline: A = operand read, O = result register. Full throughput of 1 op/cycle. Backpressure and flush supported.

Parameters:
- XLEN, 32, datapath width.
- PREG_W, 6, physical tag width; must match the package tag type.
- ROB_W, 5, ROB tag width; must match the package.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  mispredict flush; kills all in-flight ops.
- issue_valid_i  in  1  RS presents a packet.
- issue_ready_o  out  1  FU can accept the packet this cycle.
- issue_pkt_i  in  issue_pkt_t  pc, rob_tag, rs1_tag, rs2_tag, rd_tag, rd_used, alu_op, imm, src2_is_imm, src1_is_pc.
- prf_rs1_addr_o  out  PREG_W  PRF read address, port 1.
- prf_rs2_addr_o  out  PREG_W  PRF read address, port 2.
- prf_rs1_data_i  in  XLEN  synchronous-read data, valid 1 cycle after address.
- prf_rs2_data_i  in  XLEN  same, port 2.
- cdb_valid_o  out  1  result available.
- cdb_ready_i  in  1  arbiter takes the result.
- cdb_pkt_o  out  cdb_pkt_t  rob_tag, rd_tag, rd_used, value.

Behaviour:
- Reset:
  - a_valid, o_valid, cdb_valid_o = 0; cdb_pkt_o = 0; hold registers = 0.
  - issue_ready_o = 1 from the first cycle after reset deasserts.
- Addressing: prf_rs*_addr_o driven combinationally from issue_pkt_i tags every cycle, regardless of valid.
- Issue fire (issue_valid_i & issue_ready_o): packet latched into stage A; a_fresh = 1.
- Stage A:
  - Cycle after capture (a_fresh = 1): operands come from prf_rs*_data_i.
  - If A stalls that cycle, the PRF data is copied into hold registers, a_fresh clears, and later cycles use the held values.
- Operand select:
  - op1 = src1_is_pc ? pc : rs1 value.
  - op2 = src2_is_imm ? imm : rs2 value.
- Handshake rules:
  - o_adv = !o_valid | cdb_ready_i.
  - A advances into O when a_valid & o_adv.
  - issue_ready_o = !flush_i & (!a_valid | o_adv). Combinational, no dependence on issue_valid_i.
  - Full chain: A and O both occupied with cdb_ready_i = 0 gives issue_ready_o = 0. The pipeline holds; cdb_pkt_o stays stable while cdb_valid_o = 1.
  - A CDB take and a new A→O move in the same cycle give back-to-back results with no bubble.
- Latency: fire at cycle N gives cdb_valid_o = 1 at N+2 when unstalled.
- ALU ops (alu_op_e):
  - ADD, SUB, AND, OR, XOR: wrap mod 2^XLEN.
  - SLL, SRL, SRA: shift amount is op2[4:0].
  - SLT (signed), SLTU: result 0 or 1, zero-extended.
  - LUI: result = imm.
  - AUIPC: pc + imm.
  - Undefined op codes: result 0.
- rd_used = 0: a result is still produced (for ROB completion); value is don't-care but driven 0.
- Flush (flush_i = 1 in cycle N):
  - Next cycle: a_valid = 0, o_valid = 0.
  - No fire can occur in cycle N.
  - An output handshake completing in cycle N still counts.
- Reset mid-operation: all in-flight ops are dropped and no result is emitted. Same for flush.

Decomposition:
- ooop_types.sv gains:
  - alu_op_e.
  - New issue_pkt_t fields: alu_op, imm, src2_is_imm, src1_is_pc, rd_used.
  - cdb_pkt_t.
- XLEN lives in the package as a localparam.
- One combinational sub-module, alu_core (op1, op2, alu_op → result). Pipeline and handshake logic stay in alu_fu.

Test Plan:
- Single ADD, rs1 = 5, rs2 = 7, rob = 3, rd = 12 → cdb_valid_o at N+2, value = 12, rob_tag = 3, rd_tag = 12.
- 8 back-to-back ops with cdb_ready_i = 1 → 8 results on consecutive cycles, issue_ready_o stays 1, order preserved.
- cdb_ready_i held 0 for 4 cycles after first result:
  - issue_ready_o drops after 2 ops.
  - Stalled-A op uses held operands even though PRF data changes to 0xDEADBEEF.
  - Both results correct, in order, once released.
- Ops with op1 = 0x80000000, op2 = 1:
  - SRA → 0xC0000000; SRL → 0x40000000.
  - SLT → 1; SLTU → 0.
  - SUB → 0x7FFFFFFF.
  - AUIPC with pc = 0x100, imm = 0x2000 → 0x2100.
- flush_i with A and O full and cdb_ready_i = 0 → no cdb_valid_o the next cycle; issue_ready_o = 0 during the flush cycle; the next issued op completes normally.
- rst asserted with two ops in flight → all outputs 0 next cycle; no stale result appears after rst deasserts.
